// File: rtl/regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// regfile_wb_sched
//
// Writeback scheduler for the 16 x 32-bit register file. NREQ writeback
// requesters (ALU, load, multiply, link, ...) compete for two general write
// ports and the PC (R15) write port. Grants are combinational, with a
// round-robin starting point. The port outputs are registered so that they
// hold steady for a full cycle around the register file's falling-edge update.
// An optional per-register pending scoreboard lets the issue stage detect
// RAW/WAW hazards.
//
// Handshake: requester i transfers when req_valid[i] && req_ready[i] at a rising
// edge of clk. A requester holds req_addr/req_data stable until it is accepted.
// req_ready is all zero while rst or flush is high.
//
// Optional feature macro: WB_SCOREBOARD_EN
//   defined   : busy tracks reservations (rsv_valid/rsv_addr) and pending writes
//   undefined : no scoreboard state, busy is tied to 0, rsv_* are ignored
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/addr/data          per-requester writeback request
//   req_ready                    per-requester grant (combinational)
//   flush                        pipeline flush: no grants, drop busy state
//   rsv_valid, rsv_addr          destination register reservation
//   busy                         pending-write mask, bit r = R(r) pending
//   write_address/data/enable    general write port 1 (registered)
//   write_address2/data2/enable2 general write port 2 (registered)
//   pc_update, pc_write          PC write port (registered)
//   rr_ptr_dbg                   current round-robin start index
// -----------------------------------------------------------------------------
module regfile_wb_sched #(
    parameter int N    = 32,
    parameter int NREQ = 4,
    localparam int PW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_addr,
    input  logic [N*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              flush,
    input  logic              rsv_valid,
    input  logic [3:0]        rsv_addr,
    output logic [15:0]       busy,
    output logic [3:0]        write_address,
    output logic [N-1:0]      write_data,
    output logic              write_enable,
    output logic [3:0]        write_address2,
    output logic [N-1:0]      write_data2,
    output logic              write_enable2,
    output logic [N-1:0]      pc_update,
    output logic              pc_write,
    output logic [PW-1:0]     rr_ptr_dbg
);

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] grant;
    logic            pc_hit, p1_hit, p2_hit;
    logic [N-1:0]    pc_data_c, p1_data_c, p2_data_c;
    logic [3:0]      p1_addr_c, p2_addr_c;
    logic [PW-1:0]   last_c;

    logic [3:0]      wa1_q, wa2_q;
    logic [N-1:0]    wd1_q, wd2_q, pcd_q;
    logic            we1_q, we2_q, pcw_q;

    // Round-robin arbitration. Requesters are visited starting at rr_ptr_q;
    // an R15 request may only use the PC port, and a second general-port
    // grant must not target the same register as port 1 in the same cycle.
    always_comb begin
        int idx;
        grant     = '0;
        pc_hit    = 1'b0;
        p1_hit    = 1'b0;
        p2_hit    = 1'b0;
        pc_data_c = '0;
        p1_data_c = '0;
        p2_data_c = '0;
        p1_addr_c = '0;
        p2_addr_c = '0;
        last_c    = rr_ptr_q;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                if (req_addr[4*idx +: 4] == 4'd15) begin
                    if (!pc_hit) begin
                        pc_hit     = 1'b1;
                        grant[idx] = 1'b1;
                        pc_data_c  = req_data[N*idx +: N];
                        last_c     = PW'(idx);
                    end
                end else if (!p1_hit) begin
                    p1_hit     = 1'b1;
                    grant[idx] = 1'b1;
                    p1_addr_c  = req_addr[4*idx +: 4];
                    p1_data_c  = req_data[N*idx +: N];
                    last_c     = PW'(idx);
                end else if (!p2_hit && (req_addr[4*idx +: 4] != p1_addr_c)) begin
                    p2_hit     = 1'b1;
                    grant[idx] = 1'b1;
                    p2_addr_c  = req_addr[4*idx +: 4];
                    p2_data_c  = req_data[N*idx +: N];
                    last_c     = PW'(idx);
                end
            end
        end
        // Reset and flush suppress every grant, so nothing transfers and the
        // round-robin pointer holds.
        if (rst || flush) begin
            grant  = '0;
            pc_hit = 1'b0;
            p1_hit = 1'b0;
            p2_hit = 1'b0;
            last_c = rr_ptr_q;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (|grant) begin
            if (last_c == PW'(NREQ - 1)) rr_ptr_d = '0;
            else                         rr_ptr_d = last_c + PW'(1);
        end
    end

    assign req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            wa1_q    <= '0;
            wd1_q    <= '0;
            we1_q    <= 1'b0;
            wa2_q    <= '0;
            wd2_q    <= '0;
            we2_q    <= 1'b0;
            pcd_q    <= '0;
            pcw_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we1_q    <= p1_hit;
            we2_q    <= p2_hit;
            pcw_q    <= pc_hit;
            // Address/data only move on a grant; the enables qualify them.
            if (p1_hit) begin
                wa1_q <= p1_addr_c;
                wd1_q <= p1_data_c;
            end
            if (p2_hit) begin
                wa2_q <= p2_addr_c;
                wd2_q <= p2_data_c;
            end
            if (pc_hit) pcd_q <= pc_data_c;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [15:0] busy_q, busy_d;
    logic [15:0] set_mask, clr_mask;

    // Set beats clear so a reservation made in the same cycle as an older
    // write to that register survives. The bit is not counted: with two
    // outstanding writes the first one clears it.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid) set_mask[rsv_addr] = 1'b1;
        if (p1_hit)    clr_mask[p1_addr_c] = 1'b1;
        if (p2_hit)    clr_mask[p2_addr_c] = 1'b1;
        if (pc_hit)    clr_mask[15] = 1'b1;
        if (flush) busy_d = '0;
        else       busy_d = (busy_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy = busy_q;
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid, rsv_addr};
    assign busy       = '0;
`endif

    assign write_address  = wa1_q;
    assign write_data     = wd1_q;
    assign write_enable   = we1_q;
    assign write_address2 = wa2_q;
    assign write_data2    = wd2_q;
    assign write_enable2  = we2_q;
    assign pc_update      = pcd_q;
    assign pc_write       = pcw_q;
    assign rr_ptr_dbg     = rr_ptr_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_sched
//
// Directed bench for regfile_wb_sched: reset, round-robin sharing of the two
// general ports, same-address conflict, PC port, scoreboard, flush and reset
// while ports are active. Inputs are driven 1 time unit after a rising edge;
// combinational grants are sampled a further unit later and registered
// outputs are sampled 1 unit after the edge that loads them.
// -----------------------------------------------------------------------------
module tb_regfile_wb_sched;
    localparam int N    = 32;
    localparam int NREQ = 4;
`ifdef WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_addr;
    logic [N*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              flush;
    logic              rsv_valid;
    logic [3:0]        rsv_addr;
    logic [15:0]       busy;
    logic [3:0]        write_address, write_address2;
    logic [N-1:0]      write_data, write_data2, pc_update;
    logic              write_enable, write_enable2, pc_write;
    logic [1:0]        rr_ptr_dbg;

    int errors = 0;
    int checks = 0;

    regfile_wb_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .flush(flush),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .busy(busy),
        .write_address(write_address), .write_data(write_data),
        .write_enable(write_enable),
        .write_address2(write_address2), .write_data2(write_data2),
        .write_enable2(write_enable2),
        .pc_update(pc_update), .pc_write(pc_write),
        .rr_ptr_dbg(rr_ptr_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic [3:0] a, input logic [N-1:0] d);
        req_valid[i]        = 1'b1;
        req_addr[4*i +: 4]  = a;
        req_data[N*i +: N]  = d;
    endtask

    task automatic drop_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    task automatic clear_inputs;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        flush     = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        set_req(0, 4'd1, 32'h1); set_req(1, 4'd2, 32'h2);
        set_req(2, 4'd3, 32'h3); set_req(3, 4'd15, 32'h4);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        tick();
        tick();
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we1: got %b expected 0", write_enable); end
        checks++; if (write_enable2 !== 1'b0) begin errors++; $display("FAIL reset_we2: got %b expected 0", write_enable2); end
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL reset_pcw: got %b expected 0", pc_write); end
        checks++; if (write_address !== 4'd0 || write_data !== 32'd0) begin errors++; $display("FAIL reset_port1: got %h/%h expected 0/0", write_address, write_data); end
        checks++; if (write_address2 !== 4'd0 || write_data2 !== 32'd0 || pc_update !== 32'd0) begin errors++; $display("FAIL reset_port2_pc: got %h/%h/%h expected 0/0/0", write_address2, write_data2, pc_update); end
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0000", busy); end
        checks++; if (rr_ptr_dbg !== 2'd0) begin errors++; $display("FAIL reset_rr: got %0d expected 0", rr_ptr_dbg); end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_round_robin;
        do_reset();
        set_req(0, 4'd1, 32'hAAAA_0001);
        set_req(1, 4'd2, 32'hBBBB_0002);
        set_req(2, 4'd3, 32'hCCCC_0003);
        set_req(3, 4'd4, 32'hDDDD_0004);
        #1;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL rr_ready1: got %b expected 0011", req_ready); end
        tick();
        checks++; if (write_enable !== 1'b1 || write_address !== 4'd1 || write_data !== 32'hAAAA_0001) begin errors++; $display("FAIL rr_port1_a: got %b/%h/%h expected 1/1/aaaa0001", write_enable, write_address, write_data); end
        checks++; if (write_enable2 !== 1'b1 || write_address2 !== 4'd2 || write_data2 !== 32'hBBBB_0002) begin errors++; $display("FAIL rr_port2_b: got %b/%h/%h expected 1/2/bbbb0002", write_enable2, write_address2, write_data2); end
        checks++; if (rr_ptr_dbg !== 2'd2) begin errors++; $display("FAIL rr_ptr_after1: got %0d expected 2", rr_ptr_dbg); end
        drop_req(0); drop_req(1);
        #1;
        checks++; if (req_ready !== 4'b1100) begin errors++; $display("FAIL rr_ready2: got %b expected 1100", req_ready); end
        tick();
        checks++; if (write_enable !== 1'b1 || write_address !== 4'd3 || write_data !== 32'hCCCC_0003) begin errors++; $display("FAIL rr_port1_c: got %b/%h/%h expected 1/3/cccc0003", write_enable, write_address, write_data); end
        checks++; if (write_enable2 !== 1'b1 || write_address2 !== 4'd4 || write_data2 !== 32'hDDDD_0004) begin errors++; $display("FAIL rr_port2_d: got %b/%h/%h expected 1/4/dddd0004", write_enable2, write_address2, write_data2); end
        checks++; if (rr_ptr_dbg !== 2'd0) begin errors++; $display("FAIL rr_ptr_wrap: got %0d expected 0", rr_ptr_dbg); end
        drop_req(2); drop_req(3);
        tick();
        checks++; if (write_enable !== 1'b0 || write_enable2 !== 1'b0) begin errors++; $display("FAIL rr_idle_we: got %b%b expected 00", write_enable, write_enable2); end
    endtask

    task automatic test_same_addr;
        do_reset();
        set_req(0, 4'd5, 32'h0000_0055);
        set_req(1, 4'd5, 32'h0000_0066);
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL same_ready1: got %b expected 0001", req_ready); end
        tick();
        checks++; if (write_enable !== 1'b1 || write_address !== 4'd5 || write_data !== 32'h55) begin errors++; $display("FAIL same_port1_first: got %b/%h/%h expected 1/5/55", write_enable, write_address, write_data); end
        checks++; if (write_enable2 !== 1'b0) begin errors++; $display("FAIL same_we2: got %b expected 0", write_enable2); end
        drop_req(0);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL same_ready2: got %b expected 0010", req_ready); end
        tick();
        checks++; if (write_enable !== 1'b1 || write_address !== 4'd5 || write_data !== 32'h66) begin errors++; $display("FAIL same_port1_second: got %b/%h/%h expected 1/5/66", write_enable, write_address, write_data); end
        checks++; if (rr_ptr_dbg !== 2'd2) begin errors++; $display("FAIL same_rr: got %0d expected 2", rr_ptr_dbg); end
        drop_req(1);
        tick();
    endtask

    task automatic test_pc;
        do_reset();
        set_req(0, 4'd15, 32'h0000_0100);
        set_req(1, 4'd15, 32'h0000_0200);
        set_req(2, 4'd7,  32'h0000_0777);
        #1;
        checks++; if (req_ready !== 4'b0101) begin errors++; $display("FAIL pc_ready1: got %b expected 0101", req_ready); end
        tick();
        checks++; if (pc_write !== 1'b1 || pc_update !== 32'h100) begin errors++; $display("FAIL pc_first: got %b/%h expected 1/100", pc_write, pc_update); end
        checks++; if (write_enable !== 1'b1 || write_address !== 4'd7 || write_data !== 32'h777) begin errors++; $display("FAIL pc_port1_r7: got %b/%h/%h expected 1/7/777", write_enable, write_address, write_data); end
        checks++; if (write_enable2 !== 1'b0) begin errors++; $display("FAIL pc_we2: got %b expected 0", write_enable2); end
        checks++; if (rr_ptr_dbg !== 2'd3) begin errors++; $display("FAIL pc_rr: got %0d expected 3", rr_ptr_dbg); end
        drop_req(0); drop_req(2);
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL pc_ready2: got %b expected 0010", req_ready); end
        tick();
        checks++; if (pc_write !== 1'b1 || pc_update !== 32'h200) begin errors++; $display("FAIL pc_second: got %b/%h expected 1/200", pc_write, pc_update); end
        checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL pc_we1_drop: got %b expected 0", write_enable); end
        drop_req(1);
        tick();
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL pc_idle: got %b expected 0", pc_write); end
    endtask

    task automatic test_scoreboard;
        do_reset();
        rsv_valid = 1'b1; rsv_addr = 4'd9;
        tick();
        rsv_valid = 1'b0;
        checks++; if (busy !== (SB ? 16'h0200 : 16'h0)) begin errors++; $display("FAIL sb_set_e0: got %h expected %h", busy, (SB ? 16'h0200 : 16'h0)); end
        tick();
        checks++; if (busy !== (SB ? 16'h0200 : 16'h0)) begin errors++; $display("FAIL sb_hold_e1: got %h expected %h", busy, (SB ? 16'h0200 : 16'h0)); end
        tick();
        checks++; if (busy !== (SB ? 16'h0200 : 16'h0)) begin errors++; $display("FAIL sb_hold_e2: got %h expected %h", busy, (SB ? 16'h0200 : 16'h0)); end
        set_req(2, 4'd9, 32'h0000_0999);
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL sb_ready: got %b expected 0100", req_ready); end
        tick();
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL sb_clear_e3: got %h expected 0000", busy); end
        checks++; if (write_enable !== 1'b1 || write_address !== 4'd9) begin errors++; $display("FAIL sb_write_r9: got %b/%h expected 1/9", write_enable, write_address); end
        // reservation and write of R9 in the same cycle
        set_req(2, 4'd9, 32'h0000_099A);
        rsv_valid = 1'b1; rsv_addr = 4'd9;
        tick();
        rsv_valid = 1'b0;
        drop_req(2);
        checks++; if (busy !== (SB ? 16'h0200 : 16'h0)) begin errors++; $display("FAIL sb_set_wins: got %h expected %h", busy, (SB ? 16'h0200 : 16'h0)); end
        checks++; if (write_data !== 32'h099A) begin errors++; $display("FAIL sb_same_cycle_data: got %h expected 0000099a", write_data); end
        // reserving an already-busy register keeps it busy
        rsv_valid = 1'b1; rsv_addr = 4'd9;
        tick();
        rsv_valid = 1'b0;
        checks++; if (busy !== (SB ? 16'h0200 : 16'h0)) begin errors++; $display("FAIL sb_rsv_busy: got %h expected %h", busy, (SB ? 16'h0200 : 16'h0)); end
        set_req(0, 4'd9, 32'h0000_0900);
        tick();
        drop_req(0);
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL sb_waw_clear: got %h expected 0000", busy); end
    endtask

    task automatic test_flush;
        do_reset();
        for (int r = 4; r < 8; r++) begin
            rsv_valid = 1'b1; rsv_addr = 4'(r);
            tick();
        end
        rsv_valid = 1'b0;
        checks++; if (busy !== (SB ? 16'h00F0 : 16'h0)) begin errors++; $display("FAIL flush_busy_pre: got %h expected %h", busy, (SB ? 16'h00F0 : 16'h0)); end
        set_req(3, 4'd3, 32'h0000_0333);
        tick();
        drop_req(3);
        set_req(0, 4'd1, 32'h0000_0111);
        set_req(1, 4'd2, 32'h0000_0222);
        flush = 1'b1;
        rsv_valid = 1'b1; rsv_addr = 4'd12;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL flush_ready: got %b expected 0000", req_ready); end
        checks++; if (write_enable !== 1'b1 || write_address !== 4'd3) begin errors++; $display("FAIL flush_prior_write: got %b/%h expected 1/3", write_enable, write_address); end
        tick();
        flush = 1'b0;
        rsv_valid = 1'b0;
        checks++; if (write_enable !== 1'b0 || write_enable2 !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL flush_enables: got %b%b%b expected 000", write_enable, write_enable2, pc_write); end
        checks++; if (busy !== 16'h0) begin errors++; $display("FAIL flush_busy: got %h expected 0000", busy); end
        #1;
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL flush_resume_ready: got %b expected 0011", req_ready); end
        tick();
        checks++; if (write_address !== 4'd1 || write_data !== 32'h111 || write_address2 !== 4'd2 || write_data2 !== 32'h222) begin errors++; $display("FAIL flush_resume: got %h/%h %h/%h expected 1/111 2/222", write_address, write_data, write_address2, write_data2); end
        drop_req(0); drop_req(1);
        tick();
    endtask

    task automatic test_rst_active;
        do_reset();
        rsv_valid = 1'b1; rsv_addr = 4'd10;
        set_req(1, 4'd8, 32'h0000_0888);
        set_req(2, 4'd6, 32'h0000_0666);
        #1;
        checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL rsta_ready: got %b expected 0110", req_ready); end
        tick();
        rsv_valid = 1'b0;
        checks++; if (write_enable !== 1'b1 || write_address !== 4'd8 || write_enable2 !== 1'b1 || write_address2 !== 4'd6) begin errors++; $display("FAIL rsta_active: got %b/%h %b/%h expected 1/8 1/6", write_enable, write_address, write_enable2, write_address2); end
        checks++; if (rr_ptr_dbg !== 2'd3) begin errors++; $display("FAIL rsta_rr_pre: got %0d expected 3", rr_ptr_dbg); end
        checks++; if (busy !== (SB ? 16'h0400 : 16'h0)) begin errors++; $display("FAIL rsta_busy_pre: got %h expected %h", busy, (SB ? 16'h0400 : 16'h0)); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rsta_ready_rst: got %b expected 0000", req_ready); end
        tick();
        rst = 1'b0;
        checks++; if (write_enable !== 1'b0 || write_enable2 !== 1'b0 || pc_write !== 1'b0) begin errors++; $display("FAIL rsta_enables: got %b%b%b expected 000", write_enable, write_enable2, pc_write); end
        checks++; if (busy !== 16'h0 || rr_ptr_dbg !== 2'd0) begin errors++; $display("FAIL rsta_busy_rr: got %h/%0d expected 0000/0", busy, rr_ptr_dbg); end
        drop_req(1); drop_req(2);
        set_req(0, 4'd12, 32'h0000_0C0C);
        set_req(3, 4'd13, 32'h0000_0D0D);
        #1;
        checks++; if (req_ready !== 4'b1001) begin errors++; $display("FAIL rsta_ready_post: got %b expected 1001", req_ready); end
        tick();
        checks++; if (write_address !== 4'd12 || write_data !== 32'h0C0C || write_address2 !== 4'd13 || write_data2 !== 32'h0D0D) begin errors++; $display("FAIL rsta_order: got %h/%h %h/%h expected c/c0c d/d0d", write_address, write_data, write_address2, write_data2); end
        drop_req(0); drop_req(3);
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_round_robin();
        test_same_addr();
        test_pc();
        test_scoreboard();
        test_flush();
        test_rst_active();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Writeback scheduler for the 16 x 32-bit register file.
- Shares the two general write ports and the PC write port among NREQ writeback requesters (ALU, load, multiply, link) using valid/ready handshakes and round-robin priority.
- Keeps a per-register pending scoreboard so the issue stage can detect RAW/WAW hazards.
- Outputs are registered and held for a full cycle, so the register file captures them on its falling-edge update.

Parameters:
- N, 32, register data width.
- NREQ, 4, number of writeback requesters (2..8).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  requester i has a writeback pending.
- req_addr  in  4*NREQ  destination register of requester i, slice [4i+3:4i].
- req_data  in  N*NREQ  write data of requester i, slice [Ni+N-1:Ni].
- req_ready  out  NREQ  grant to requester i; combinational this cycle.
- flush  in  1  pipeline flush.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_addr  in  4  register being reserved.
- busy  out  16  pending-write mask, bit r = register r awaiting writeback.
- write_address, write_data, write_enable  out  4, N, 1  general write port 1 (registered).
- write_address2, write_data2, write_enable2  out  4, N, 1  general write port 2 (registered).
- pc_update, pc_write  out  N, 1  PC (R15) write port (registered).

Behaviour:
- Reset (rst=1 at rising edge): all enables 0; all addresses and data 0; rr_ptr=0; busy=0; req_ready=0 while rst=1.
- Handshake: transfer occurs when req_valid[i] and req_ready[i] are both 1 at a rising edge. A requester holds addr/data stable until accepted. req_ready never depends on a requester's own ready.
- Arbitration (combinational):
  - Visit requesters in order rr_ptr, rr_ptr+1, ... mod NREQ.
  - A valid request with addr=15 is granted to the PC port if no R15 write has yet been granted this cycle; otherwise it waits.
  - A valid request with addr!=15 takes the first free general port (port 1, then port 2) if its address differs from the address already granted to port 1 this cycle; otherwise it waits.
  - At most 3 grants per cycle: 2 general, 1 PC.
- rr_ptr update: becomes (index of last granted requester + 1) mod NREQ; unchanged if nothing is granted.
- Latency: accepted at edge k, driven on port outputs from edge k until edge k+1 (1 cycle). Enables fall to 0 on the following edge when there is no new grant.
- flush=1:
  - req_ready is all 0 that cycle.
  - At the edge: port enables go to 0 and busy is cleared to 0.
  - rsv_valid in the same cycle is ignored.
  - Writes already driven before the flush edge complete normally.
- Scoreboard:
  - rsv_valid sets busy[rsv_addr] at the edge.
  - A grant to register r clears busy[r] at the same edge.
  - Set and clear of the same register in one cycle: set wins.
  - Reserving an already-busy register keeps it busy.
  - The busy bit is not counted. A WAW reservation is cleared by the first write; the issue stage must stall on busy.
- Unreserved writes are legal; clearing a 0 bit has no effect.
- rst has priority over flush; flush has priority over everything else.

Optional Feature:
- Macro WB_SCOREBOARD_EN.
- Defined: scoreboard, rsv_valid/rsv_addr and busy behave as above.
- Undefined: no scoreboard state; busy is tied to 0; rsv_valid and rsv_addr are ignored. Arbitration, ports and flush are unchanged.

Test Plan:
- Reset, then req_valid=4'b1111 with addrs 1,2,3,4 and data A,B,C,D, held across edges -> first edge drives port1=R1/A and port2=R2/B, rr_ptr=2. Next edge drives R3/C and R4/D.
- req0 and req1 both addr 5 (rr_ptr=0) -> only req0 is granted. req1 is granted the next cycle; write_enable2 stays 0 on the first cycle.
- req0 addr 15 data 0x100, req1 addr 15, req2 addr 7 -> pc_write=1 with pc_update=0x100 and port1=R7 in the same cycle. req1 PC write lands one cycle later.
- rsv R9 at edge 0, req2 addr 9 granted at edge 3 -> busy[9]=1 for edges 1..3, back to 0 after edge 3. rsv R9 plus grant R9 in the same cycle -> busy[9] stays 1.
- busy=0x00F0, requests pending, flush pulsed 1 cycle -> req_ready=0 that cycle. Next cycle busy=0 and all enables 0; grants resume the cycle after.
- rst asserted while ports are active -> all enables 0, busy=0 after the edge. Arbitration after reset starts at requester 0.
